system: RTL and testbench

SYSTEM -- requirements
Module: system

---
 rtl/system.sv | 146 ++++++++++++++
 tb/tb_system.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/system.sv
// Byte-serial 16/16 unsigned restoring divider: four operand bytes in over a
// dataready/readyToAccept handshake, four result bytes out on receiveData pulses.
module system (
  input  logic       clk,
  input  logic       rst,
  input  logic       dataready,
  input  logic [7:0] Data_in,
  input  logic       receiveData,
  output logic [7:0] Data_out,
  output logic       OutBuffFull,
  output logic       error,
  output logic       readyToAccept
);

  typedef enum logic [1:0] {
    IDLE_IN = 2'd0,
    ACK     = 2'd1,
    DIVIDE  = 2'd2,
    OUT     = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  cnt_reg, cnt_next;
  logic        error_reg, error_next;
  logic [15:0] rem_reg, quo_reg;
  logic [3:0]  iter_reg;
  logic [7:0]  slot [4];

  logic        capture;
  logic        start_div;
  logic        div_zero;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic [16:0] rem_shift;
  logic [16:0] trial;

  assign dividend  = {slot[1], slot[0]};
  assign divisor   = {slot[3], slot[2]};
  assign div_zero  = (divisor == 16'd0);
  assign capture   = (state_reg == IDLE_IN) && dataready;
  assign start_div = (state_reg == ACK) && !dataready && (cnt_reg == 2'd3);

  // Operand byte slots, each written only when the shared counter selects it.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slot
      logic [7:0] byte_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          byte_reg <= 8'h00;
        end else if (capture && (cnt_reg == 2'(gi))) begin
          byte_reg <= Data_in;
        end
      end
      assign slot[gi] = byte_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE_IN;
      cnt_reg   <= 2'd0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      error_reg <= error_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    error_next = error_reg;
    case (state_reg)
      IDLE_IN: begin
        if (dataready) begin
          state_next = ACK;
          error_next = 1'b0;
        end
      end
      ACK: begin
        if (!dataready) begin
          cnt_next   = cnt_reg + 2'd1;
          state_next = (cnt_reg == 2'd3) ? DIVIDE : IDLE_IN;
        end
      end
      DIVIDE: begin
        if (div_zero) begin
          error_next = 1'b1;
          cnt_next   = 2'd0;
          state_next = IDLE_IN;
        end else if (iter_reg == 4'd15) begin
          cnt_next   = 2'd0;
          state_next = OUT;
        end
      end
      OUT: begin
        if (receiveData) begin
          cnt_next = cnt_reg + 2'd1;
          if (cnt_reg == 2'd3) begin
            state_next = IDLE_IN;
          end
        end
      end
      default: state_next = IDLE_IN;
    endcase
  end

  // Shifted remainder never exceeds 2*divisor-1, so a 17-bit trial suffices.
  assign rem_shift = {rem_reg, quo_reg[15]};
  assign trial     = rem_shift - {1'b0, divisor};

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_reg  <= 16'd0;
      quo_reg  <= 16'd0;
      iter_reg <= 4'd0;
    end else if (start_div) begin
      rem_reg  <= 16'd0;
      quo_reg  <= dividend;
      iter_reg <= 4'd0;
    end else if ((state_reg == DIVIDE) && !div_zero) begin
      rem_reg  <= trial[16] ? rem_shift[15:0] : trial[15:0];
      quo_reg  <= {quo_reg[14:0], ~trial[16]};
      iter_reg <= iter_reg + 4'd1;
    end
  end

  always_comb begin
    Data_out = 8'h00;
    if (state_reg == OUT) begin
      case (cnt_reg)
        2'd0:    Data_out = quo_reg[7:0];
        2'd1:    Data_out = quo_reg[15:8];
        2'd2:    Data_out = rem_reg[7:0];
        default: Data_out = rem_reg[15:8];
      endcase
    end
  end

  assign OutBuffFull   = (state_reg == OUT);
  assign readyToAccept = (state_reg == ACK);
  assign error         = error_reg;

endmodule

// File: tb/tb_system.sv
// Scoreboard bench for the byte-serial divider: expected result bytes are
// queued when operands are sent and compared as each byte is consumed.
module tb_system;

  logic       clk = 1'b0;
  logic       rst;
  logic       dataready;
  logic [7:0] Data_in;
  logic       receiveData;
  logic [7:0] Data_out;
  logic       OutBuffFull;
  logic       error;
  logic       readyToAccept;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q [$];

  system dut (
    .clk          (clk),
    .rst          (rst),
    .dataready    (dataready),
    .Data_in      (Data_in),
    .receiveData  (receiveData),
    .Data_out     (Data_out),
    .OutBuffFull  (OutBuffFull),
    .error        (error),
    .readyToAccept(readyToAccept)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input bit first);
    int n;
    @(negedge clk);
    dataready = 1'b1;
    Data_in   = b;
    n = 0;
    @(negedge clk);
    while (!readyToAccept && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("rta_rise", readyToAccept, 1);
    if (first) check("err_clear", error, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rta_hold", readyToAccept, 1);
    end
    dataready = 1'b0;
    Data_in   = 8'($urandom);
    @(negedge clk);
    check("rta_fall", readyToAccept, 0);
  endtask

  task automatic send_txn(input logic [15:0] dvd, input logic [15:0] dvs, input int hold);
    logic [15:0] q;
    logic [15:0] r;
    if (dvs != 16'd0) begin
      q = dvd / dvs;
      r = dvd % dvs;
      exp_q.push_back(q[7:0]);
      exp_q.push_back(q[15:8]);
      exp_q.push_back(r[7:0]);
      exp_q.push_back(r[15:8]);
    end
    send_byte(dvd[7:0],  hold, 1'b1);
    send_byte(dvd[15:8], 0,    1'b0);
    send_byte(dvs[7:0],  0,    1'b0);
    send_byte(dvs[15:8], 0,    1'b0);
  endtask

  // Entered at the first falling edge after the last ACK exit.
  task automatic read_result(input logic [15:0] dvd, input logic [15:0] dvs);
    int n;
    logic [7:0] exp;
    logic [7:0] got [4];
    n = 1;
    while (!OutBuffFull && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("obf_latency", 16'(n <= 18 && OutBuffFull), 1);
    for (int i = 0; i < 4; i++) begin
      if (exp_q.size() == 0) begin
        check("queue_empty", 1, 0);
        exp = 8'h00;
      end else begin
        exp = exp_q.pop_front();
      end
      got[i] = Data_out;
      check($sformatf("data_out%0d", i), Data_out, exp);
      check("obf_high", OutBuffFull, 1);
      receiveData = 1'b1;
      @(negedge clk);
      receiveData = 1'b0;
    end
    check("obf_clear", OutBuffFull, 0);
    $display("txn %0d / %0d -> bytes %02h %02h %02h %02h", dvd, dvs, got[0], got[1], got[2], got[3]);
  endtask

  initial begin
    logic [15:0] a;
    logic [15:0] d;
    rst         = 1'b1;
    dataready   = 1'b0;
    receiveData = 1'b0;
    Data_in     = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_data_out", Data_out, 0);
    check("rst_obf", OutBuffFull, 0);
    check("rst_error", error, 0);
    check("rst_rta", readyToAccept, 0);

    // Stray consume pulse while idle must not disturb the byte counter.
    receiveData = 1'b1;
    @(negedge clk);
    receiveData = 1'b0;

    send_txn(16'h002D, 16'h0007, 0); read_result(16'h002D, 16'h0007);
    send_txn(16'hFFFF, 16'h0001, 0); read_result(16'hFFFF, 16'h0001);
    send_txn(16'h0005, 16'h0100, 0); read_result(16'h0005, 16'h0100);

    send_txn(16'h0010, 16'h0000, 0);
    repeat (2) @(negedge clk);
    check("div0_error", error, 1);
    check("div0_obf", OutBuffFull, 0);
    repeat (20) @(negedge clk);
    check("div0_obf_late", OutBuffFull, 0);
    $display("txn 16 / 0 -> divide-by-zero flagged");
    send_txn(16'h000A, 16'h0003, 0); read_result(16'h000A, 16'h0003);

    send_txn(16'd1000, 16'd33, 4); read_result(16'd1000, 16'd33);

    send_txn(16'd1234, 16'd56, 0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check("abort_data_out", Data_out, 0);
    check("abort_obf", OutBuffFull, 0);
    check("abort_error", error, 0);
    check("abort_rta", readyToAccept, 0);
    repeat (20) @(negedge clk);
    check("abort_obf_late", OutBuffFull, 0);
    $display("txn 1234 / 56 -> aborted by reset");
    send_txn(16'h002D, 16'h0007, 0); read_result(16'h002D, 16'h0007);

    for (int k = 0; k < 4; k++) begin
      a = 16'($urandom);
      d = 16'($urandom_range(1, 65535));
      if (k == 0) d = 16'($urandom_range(1, 255));
      send_txn(a, d, 0);
      read_result(a, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
